// File: rtl/ntt_job_sequencer.sv
// ntt_job_sequencer: moves one transform job through an ntt_engine.
// Coefficients stream in and are written through the engine rw port.
// The sequencer then pulses start and waits for done, guarded by a watchdog.
// Results are read back one word at a time and streamed out, with the final
// word tagged by out_last.
module ntt_job_sequencer #(
    parameter int N_LOG       = 3,
    parameter int N           = 2 ** N_LOG,
    parameter int TIMEOUT_CYC = 1024,
    parameter int DATA_W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              timeout_err,
    output logic [15:0]       job_count,
    output logic              eng_start,
    input  logic              eng_done,
    output logic              eng_rw_mode,
    output logic [N_LOG-1:0]  eng_rw_addr,
    output logic [DATA_W-1:0] eng_rw_data_in,
    input  logic [DATA_W-1:0] eng_rw_data_out
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [N_LOG-1:0] LAST_IDX = N_LOG'(N - 1);
    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_RD_ADDR,
        S_RD_CAP,
        S_OUT
    } state_t;

    state_t           state;
    logic [N_LOG-1:0] cnt;
    logic [WD_W-1:0]  wd;
    logic             in_fire;

    // in_ready is only high in IDLE/LOAD, so a write can only occur while
    // loading; cnt is 0 in IDLE, so it doubles as the write address there.
    assign in_fire        = in_valid & in_ready;
    assign eng_rw_mode    = in_fire;
    assign eng_rw_addr    = cnt;
    assign eng_rw_data_in = in_data;

    // Job FSM with registered handshake, status and engine-control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            wd          <= '0;
            in_ready    <= 1'b1;
            busy        <= 1'b0;
            eng_start   <= 1'b0;
            out_valid   <= 1'b0;
            out_last    <= 1'b0;
            out_data    <= '0;
            job_count   <= '0;
            timeout_err <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            if (in_fire) begin
                timeout_err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (in_fire) begin
                        busy <= 1'b1;
                        if (N == 1) begin
                            state     <= S_START;
                            in_ready  <= 1'b0;
                            eng_start <= 1'b1;
                        end else begin
                            cnt   <= N_LOG'(1);
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (in_fire) begin
                        if (cnt == LAST_IDX) begin
                            cnt       <= '0;
                            state     <= S_START;
                            in_ready  <= 1'b0;
                            eng_start <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                S_START: begin
                    wd    <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (eng_done) begin
                        cnt   <= '0;
                        state <= S_RD_ADDR;
                    end else if (wd == WD_LAST) begin
                        // Watchdog abort: drop the job without emitting words.
                        timeout_err <= 1'b1;
                        cnt         <= '0;
                        busy        <= 1'b0;
                        in_ready    <= 1'b1;
                        state       <= S_IDLE;
                    end else begin
                        wd <= wd + 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    state <= S_RD_CAP;
                end
                S_RD_CAP: begin
                    // Engine read data is registered, so it is valid now.
                    out_data  <= eng_rw_data_out;
                    out_last  <= (cnt == LAST_IDX);
                    out_valid <= 1'b1;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cnt == LAST_IDX) begin
                            job_count <= job_count + 16'd1;
                            cnt       <= '0;
                            busy      <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_RD_ADDR;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ntt_job_sequencer.sv
// Bench for ntt_job_sequencer with a behavioural q=17, N=8 NTT engine model.
module tb_ntt_job_sequencer;

    localparam int ENG_LAT = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_last;
    logic        busy;
    logic        timeout_err;
    logic [15:0] job_count;
    logic        eng_start;
    logic        eng_done = 1'b0;
    logic        eng_rw_mode;
    logic [2:0]  eng_rw_addr;
    logic [63:0] eng_rw_data_in;
    logic [63:0] eng_rw_data_out;

    ntt_job_sequencer #(.N_LOG(3), .N(8), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .timeout_err(timeout_err), .job_count(job_count),
        .eng_start(eng_start), .eng_done(eng_done), .eng_rw_mode(eng_rw_mode),
        .eng_rw_addr(eng_rw_addr), .eng_rw_data_in(eng_rw_data_in),
        .eng_rw_data_out(eng_rw_data_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0][63:0] din;
        logic [7:0][63:0] dout;
    } vec_t;

    vec_t vecs [4];
    int   n_vec = 0;
    int   n_fail = 0;
    int   n_viol = 0;
    int   n_outv = 0;
    int   n_starts = 0;
    int   exp_jobs = 0;

    // Engine model: rw memory with registered read, NTT after ENG_LAT cycles.
    logic [63:0] emem [8];
    int          eng_cnt = 0;
    bit          eng_run = 1'b0;
    bit          eng_hang = 1'b0;
    int          wr_addr_q [$];
    int          pw [8] = '{1, 2, 4, 8, 16, 15, 13, 9};
    int          acc;

    always @(posedge clk) begin
        if (eng_rw_mode) begin
            emem[eng_rw_addr] <= eng_rw_data_in;
            wr_addr_q.push_back(int'(eng_rw_addr));
        end
        eng_rw_data_out <= emem[eng_rw_addr];
        if (eng_start) begin
            eng_done <= 1'b0;
            eng_cnt  <= ENG_LAT;
            eng_run  <= 1'b1;
            n_starts++;
        end else if (eng_run) begin
            if (eng_cnt > 1) begin
                eng_cnt <= eng_cnt - 1;
            end else if (eng_hang) begin
                eng_run <= 1'b0;
            end else begin
                for (int k = 0; k < 8; k++) begin
                    acc = 0;
                    for (int j = 0; j < 8; j++)
                        acc += int'(emem[j] % 64'd17) * pw[(j * k) % 8];
                    emem[k] <= 64'(acc % 17);
                end
                eng_done <= 1'b1;
                eng_run  <= 1'b0;
            end
        end
    end

    // Output collector plus stall-stability and write-legality monitors.
    logic [63:0] got_d [$];
    bit          got_l [$];
    bit          stalled = 1'b0;
    logic [63:0] stall_d;
    logic        stall_l;

    always @(negedge clk) begin
        if (out_valid) n_outv++;
        if (stalled && out_valid && (out_data !== stall_d || out_last !== stall_l)) begin
            n_viol++;
            $display("FAIL stall_stable got=%0h/%0b required=%0h/%0b", out_data, out_last, stall_d, stall_l);
        end
        stalled = out_valid && !out_ready;
        stall_d = out_data;
        stall_l = out_last;
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
        if (!rst && eng_rw_mode && (!in_ready || eng_start)) begin
            n_viol++;
            $display("FAIL rw_write_outside_load got=1 required=0");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    task automatic send_word(input logic [63:0] d);
        bit ok;
        int i;
        ok = 1'b0;
        i = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!ok && i < 300) begin
            if (in_ready) ok = 1'b1;
            tick();
            i++;
        end
        in_valid = 1'b0;
        if (!ok) check("in_accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain(input int n, input int stall_at);
        int  i;
        bit  did_stall;
        i = 0;
        did_stall = 1'b0;
        out_ready = 1'b1;
        while ((got_d.size() < n || busy) && i < 1000) begin
            if (stall_at >= 0 && !did_stall && got_d.size() == stall_at) begin
                out_ready = 1'b0;
                repeat (5) tick();
                out_ready = 1'b1;
                did_stall = 1'b1;
            end
            tick();
            i++;
        end
        if (i >= 1000) check("drain_timeout", 64'(got_d.size()), 64'(n));
    endtask

    task automatic compare_job(input int vi, input string name);
        if (got_d.size() != 8) begin
            check({name, "_count"}, 64'(got_d.size()), 64'd8);
        end else begin
            for (int k = 0; k < 8; k++) begin
                check($sformatf("%s_data%0d", name, k), got_d[k], vecs[vi].dout[k]);
                check($sformatf("%s_last%0d", name, k), 64'(got_l[k]), 64'(k == 7));
            end
        end
        check({name, "_job_count"}, 64'(job_count), 64'(exp_jobs));
    endtask

    task automatic run_job(input int vi, input bit gap, input int stall_at, input string name);
        got_d.delete();
        got_l.delete();
        for (int k = 0; k < 8; k++) begin
            send_word(vecs[vi].din[k]);
            if (gap) tick();
        end
        drain(8, stall_at);
        exp_jobs = (exp_jobs + 1) % 65536;
        compare_job(vi, name);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout got=running required=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int starts0;
        int outv0;
        int i;
        vecs[0].dout = {64'd1, 64'd12, 64'd3, 64'd13, 64'd6, 64'd14, 64'd8, 64'd11};
        vecs[2].dout = {64'd9, 64'd13, 64'd15, 64'd16, 64'd8, 64'd4, 64'd2, 64'd1};
        vecs[3].dout = {64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd8};
        vecs[1].dout = {8{64'd1}};
        for (int k = 0; k < 8; k++) begin
            vecs[0].din[k] = 64'(k);
            vecs[1].din[k] = (k == 0) ? 64'd1 : 64'd0;
            vecs[2].din[k] = (k == 1) ? 64'd1 : 64'd0;
            vecs[3].din[k] = 64'd1;
        end

        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_job_count", 64'(job_count), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_eng_start", 64'(eng_start), 64'd0);
        check("rst_rw_mode", 64'(eng_rw_mode), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;
        tick();

        // Ramp job: write addresses, single start pulse, golden outputs.
        wr_addr_q.delete();
        starts0 = n_starts;
        run_job(0, 1'b0, -1, "ramp");
        check("ramp_writes", 64'(wr_addr_q.size()), 64'd8);
        if (wr_addr_q.size() == 8)
            for (int k = 0; k < 8; k++) check($sformatf("ramp_wraddr%0d", k), 64'(wr_addr_q[k]), 64'(k));
        check("ramp_starts", 64'(n_starts - starts0), 64'd1);

        for (int v = 1; v < 4; v++) run_job(v, 1'b0, -1, $sformatf("vec%0d", v));

        // Gapped input and a 5-cycle output stall after word 3.
        run_job(0, 1'b1, 3, "gap_stall");

        // Watchdog abort with an engine that never completes.
        eng_hang = 1'b1;
        got_d.delete();
        got_l.delete();
        outv0 = n_outv;
        for (int k = 0; k < 8; k++) send_word(vecs[1].din[k]);
        repeat (16) tick();
        check("wd_err_early", 64'(timeout_err), 64'd0);
        tick();
        check("wd_err_set", 64'(timeout_err), 64'd1);
        check("wd_busy", 64'(busy), 64'd0);
        check("wd_in_ready", 64'(in_ready), 64'd1);
        check("wd_no_out_valid", 64'(n_outv - outv0), 64'd0);
        check("wd_job_count", 64'(job_count), 64'(exp_jobs));
        eng_hang = 1'b0;
        tick();
        check("wd_err_sticky", 64'(timeout_err), 64'd1);
        send_word(vecs[1].din[0]);
        check("wd_err_cleared", 64'(timeout_err), 64'd0);
        for (int k = 1; k < 8; k++) send_word(vecs[1].din[k]);
        drain(8, -1);
        exp_jobs++;
        compare_job(1, "after_wd");

        // Reset while word 3 is being offered.
        got_d.delete();
        got_l.delete();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) send_word(vecs[0].din[k]);
        i = 0;
        while (got_d.size() < 3 && i < 200) begin tick(); i++; end
        out_ready = 1'b0;
        i = 0;
        while (!out_valid && i < 20) begin tick(); i++; end
        check("rst_mid_words_seen", 64'(got_d.size()), 64'd3);
        check("rst_mid_valid_w3", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_job_count", 64'(job_count), 64'd0);
        rst = 1'b0;
        exp_jobs = 0;
        tick();
        run_job(0, 1'b0, -1, "post_rst");

        // Three all-zero jobs streamed back to back.
        got_d.delete();
        got_l.delete();
        for (int k = 0; k < 24; k++) send_word(64'd0);
        drain(24, -1);
        exp_jobs += 3;
        check("zero_count", 64'(got_d.size()), 64'd24);
        if (got_d.size() == 24)
            for (int k = 0; k < 24; k++) begin
                check($sformatf("zero_data%0d", k), got_d[k], 64'd0);
                check($sformatf("zero_last%0d", k), 64'(got_l[k]), 64'(k % 8 == 7));
            end
        check("zero_job_count", 64'(job_count), 64'(exp_jobs));

        // job_count wrap.
        force dut.job_count = 16'hFFFF;
        tick();
        release dut.job_count;
        tick();
        check("wrap_preload", 64'(job_count), 64'hFFFF);
        exp_jobs = 16'hFFFF;
        run_job(1, 1'b0, -1, "wrap");

        check("monitor_violations", 64'(n_viol), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
